lfsr_rng: RTL and testbench
===========================

LFSR_RNG -- requirements
Module: lfsr_rng

Interface
REQ-001 Parameter WIDTH, default 6: LFSR state and output width, legal range 3..32.
REQ-002 Parameter TAPS, default 6'b000011 (WIDTH bits): feedback tap mask, with bit i set meaning state bit i enters the XOR.
REQ-003 Parameter DEFAULT_SEED, default 6'b000001 (WIDTH bits): state loaded on reset; zero SHALL be replaced by 1.
REQ-004 Parameter FREE_RUN, default 0: 1 means advance every cycle and ignore out_ready; 0 means advance only on handshake.
REQ-005 clk  input  1  sole clock; all logic on its rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 load  input  1  load seed_in into state this cycle.
REQ-008 seed_in  input  WIDTH  seed value sampled when load=1.
REQ-009 out_ready  input  1  consumer accepts rand_out.
REQ-010 out_valid  output  1  rand_out holds a valid value.
REQ-011 rand_out  output  WIDTH  current LFSR state, registered.
REQ-012 lockup  output  1  state is all-zero; generator halted.
REQ-013 period_done  output  1  one-cycle pulse when the state returns to the last loaded seed.
REQ-014 period  output  WIDTH  advance count of the most recently completed cycle.

Function
REQ-015 The next state SHALL be {^(state & TAPS), state[WIDTH-1:1]}: shift right, with the feedback bit entering the MSB.
REQ-016 rand_out SHALL equal the state register directly, with no combinational path from inputs.
REQ-017 The FSM SHALL have exactly two states, RUN and LOCKED; out_valid=1 in RUN and 0 in LOCKED; lockup=1 exactly in LOCKED.
REQ-018 An advance SHALL occur in RUN when (FREE_RUN=1) or (out_valid & out_ready); the new state appears on the cycle after the handshake.
REQ-019 With FREE_RUN=0 and out_ready=0, rand_out SHALL hold unchanged indefinitely.
REQ-020 load SHALL take priority over advance in the same cycle: state<=seed_in, the advance counter clears, and the seed register<=seed_in.
REQ-021 A load with seed_in==0 SHALL enter LOCKED; a load with a nonzero seed SHALL enter RUN from either state.
REQ-022 LOCKED SHALL hold state 0 with no advances until rst or a nonzero load.
REQ-023 The advance counter (WIDTH bits) SHALL increment on each advance and wrap modulo 2^WIDTH.
REQ-024 When an advance produces a state equal to the seed register, period_done SHALL pulse for 1 cycle (concurrent with the new rand_out), period<=counter+1, and the counter SHALL clear.
REQ-025 period SHALL hold its value between completions, and a load SHALL leave period unchanged.
REQ-026 With a primitive TAPS, period SHALL equal 2^WIDTH-1.

Reset
REQ-027 While rst=1: state<=DEFAULT_SEED (or 1 if zero), seed register<=the same value, FSM<=RUN, counter<=0, period<=0, period_done<=0.
REQ-028 In the first cycle after rst is released: out_valid=1, lockup=0, rand_out=DEFAULT_SEED.
REQ-029 rst SHALL override load and advance in the same cycle, including mid-sequence and in LOCKED.

Verification
REQ-030 Defaults, rst pulse, out_ready=1 -> rand_out 000001, 100000, 010000, 001000, 000100, 000010, 100001.
REQ-031 Defaults, out_ready=1 held 63 handshakes -> period_done pulses once, when rand_out returns to 000001; period=63.
REQ-032 FREE_RUN=0, out_ready=0 for 10 cycles -> rand_out stays 000001; then out_ready=1 for 1 cycle -> rand_out=100000 next cycle.
REQ-033 load=1 with seed_in=0 -> next cycle lockup=1, out_valid=0, rand_out=0, stable for 20 cycles; then load seed_in=6'b101010 -> RUN, rand_out=101010.
REQ-034 load and out_ready asserted in the same cycle with seed_in=6'b000111 -> rand_out=000111, not the advanced value; rst asserted mid-sequence -> rand_out=000001 and period=0 next cycle.

Source files
------------

// File: rtl/lfsr_rng.sv
// lfsr_rng: Fibonacci-style LFSR random number source with a valid/ready
// output handshake, seed loading, all-zero lockup detection and period
// measurement.
//
// Parameters
//   WIDTH         state / output width (3..32)
//   TAPS          feedback mask; bit i set means state bit i enters the XOR
//   DEFAULT_SEED  state loaded on reset (zero is replaced by 1)
//   FREE_RUN      1: advance every cycle, ignore out_ready
//                 0: advance only on out_valid & out_ready
//
// Ports
//   clk          clock, rising edge
//   rst          synchronous active-high reset
//   load         load seed_in into the state this cycle (beats an advance)
//   seed_in      seed sampled when load=1
//   out_ready    consumer accepts rand_out
//   out_valid    rand_out is valid (generator running)
//   rand_out     current LFSR state, straight from the state register
//   lockup       state is all-zero, generator halted
//   period_done  one-cycle pulse when an advance returns to the loaded seed
//   period       advance count of the most recently completed cycle
module lfsr_rng #(
    parameter int unsigned       WIDTH        = 6,
    parameter logic [WIDTH-1:0]  TAPS         = 6'b000011,
    parameter logic [WIDTH-1:0]  DEFAULT_SEED = 6'b000001,
    parameter bit                FREE_RUN     = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] seed_in,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] rand_out,
    output logic             lockup,
    output logic             period_done,
    output logic [WIDTH-1:0] period
);

    // All-zero is the LFSR's absorbing state, so never use it as a reset seed.
    localparam logic [WIDTH-1:0] RESET_SEED =
        (DEFAULT_SEED == '0) ? WIDTH'(1) : DEFAULT_SEED;

    typedef enum logic {
        RUN    = 1'b0,
        LOCKED = 1'b1
    } fsm_t;

    fsm_t             fsm_q, fsm_d;
    logic [WIDTH-1:0] state_q, state_d;
    logic [WIDTH-1:0] seed_q, seed_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic             done_q, done_d;
    logic             valid_q, valid_d;
    logic             lock_q, lock_d;

    logic             advance_c;
    logic             feedback_c;
    logic [WIDTH-1:0] shifted_c;

    // Next LFSR value: shift right, XOR of tapped bits enters the MSB.
    always_comb begin
        feedback_c = ^(state_q & TAPS);
        shifted_c  = {feedback_c, state_q[WIDTH-1:1]};
    end

    // Handshake: in RUN out_valid is high, so only out_ready gates the advance.
    always_comb begin
        advance_c = (fsm_q == RUN) && (FREE_RUN || out_ready);
    end

    // Next-state and output logic.
    always_comb begin
        fsm_d    = fsm_q;
        state_d  = state_q;
        seed_d   = seed_q;
        cnt_d    = cnt_q;
        period_d = period_q;
        done_d   = 1'b0;

        if (load) begin
            state_d = seed_in;
            seed_d  = seed_in;
            cnt_d   = '0;
            fsm_d   = (seed_in == '0) ? LOCKED : RUN;
        end else begin
            unique case (fsm_q)
                RUN: begin
                    if (advance_c) begin
                        state_d = shifted_c;
                        if (shifted_c == seed_q) begin
                            done_d   = 1'b1;
                            period_d = cnt_q + WIDTH'(1);
                            cnt_d    = '0;
                        end else begin
                            cnt_d = cnt_q + WIDTH'(1);
                        end
                        // Only reachable with a degenerate tap mask.
                        if (shifted_c == '0) begin
                            fsm_d = LOCKED;
                        end
                    end
                end
                LOCKED: begin
                    state_d = '0;
                end
                default: begin
                    fsm_d = RUN;
                end
            endcase
        end

        valid_d = (fsm_d == RUN);
        lock_d  = (fsm_d == LOCKED);
    end

    // State register; reset beats load and advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q    <= RUN;
            state_q  <= RESET_SEED;
            seed_q   <= RESET_SEED;
            cnt_q    <= '0;
            period_q <= '0;
            done_q   <= 1'b0;
            valid_q  <= 1'b1;
            lock_q   <= 1'b0;
        end else begin
            fsm_q    <= fsm_d;
            state_q  <= state_d;
            seed_q   <= seed_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            done_q   <= done_d;
            valid_q  <= valid_d;
            lock_q   <= lock_d;
        end
    end

    assign rand_out    = state_q;
    assign out_valid   = valid_q;
    assign lockup      = lock_q;
    assign period_done = done_q;
    assign period      = period_q;

endmodule

// File: tb/tb_lfsr_rng.sv
// tb_lfsr_rng: directed self-checking bench for lfsr_rng at default params.
module tb_lfsr_rng;

    logic       clk;
    logic       rst;
    logic       load;
    logic [5:0] seed_in;
    logic       out_ready;
    logic       out_valid;
    logic [5:0] rand_out;
    logic       lockup;
    logic       period_done;
    logic [5:0] period;

    int checks = 0;
    int errors = 0;

    lfsr_rng dut (
        .clk         (clk),
        .rst         (rst),
        .load        (load),
        .seed_in     (seed_in),
        .out_ready   (out_ready),
        .out_valid   (out_valid),
        .rand_out    (rand_out),
        .lockup      (lockup),
        .period_done (period_done),
        .period      (period)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; load = 1'b0; out_ready = 1'b0; seed_in = '0;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (rand_out !== 6'b000001 || out_valid !== 1'b1 || lockup !== 1'b0 ||
            period !== 6'd0 || period_done !== 1'b0) begin
            errors++;
            $display("FAIL reset: rand=%b valid=%b lock=%b period=%0d done=%b, want 000001 1 0 0 0",
                     rand_out, out_valid, lockup, period, period_done);
        end
    endtask

    task automatic test_sequence();
        logic [5:0] exp [6] = '{6'b100000, 6'b010000, 6'b001000,
                                6'b000100, 6'b000010, 6'b100001};
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            checks++;
            if (rand_out !== exp[i]) begin
                errors++;
                $display("FAIL seq[%0d]: rand=%b want %b", i, rand_out, exp[i]);
            end
        end
        out_ready = 1'b0;
    endtask

    task automatic test_period();
        int pulses = 0;
        int pulse_at = -1;
        do_reset();
        out_ready = 1'b1;
        repeat (10) step();
        // Load mid-run with out_ready still high: load wins, counter clears.
        load = 1'b1; seed_in = 6'b000001;
        step();
        load = 1'b0;
        checks++;
        if (rand_out !== 6'b000001) begin
            errors++;
            $display("FAIL period_load: rand=%b want 000001", rand_out);
        end
        for (int i = 1; i <= 63; i++) begin
            step();
            if (period_done === 1'b1) begin
                pulses++;
                pulse_at = i;
                checks++;
                if (rand_out !== 6'b000001) begin
                    errors++;
                    $display("FAIL period_pulse_rand: rand=%b want 000001", rand_out);
                end
            end
        end
        checks++;
        if (pulses != 1 || pulse_at != 63 || period !== 6'd63) begin
            errors++;
            $display("FAIL period: pulses=%0d at=%0d period=%0d, want 1 63 63",
                     pulses, pulse_at, period);
        end
        step();
        checks++;
        if (period_done !== 1'b0 || period !== 6'd63 || rand_out !== 6'b100000) begin
            errors++;
            $display("FAIL period_hold: done=%b period=%0d rand=%b, want 0 63 100000",
                     period_done, period, rand_out);
        end
        out_ready = 1'b0;
        load = 1'b1; seed_in = 6'b000101;
        step();
        load = 1'b0;
        checks++;
        if (period !== 6'd63 || rand_out !== 6'b000101) begin
            errors++;
            $display("FAIL period_after_load: period=%0d rand=%b, want 63 000101",
                     period, rand_out);
        end
    endtask

    task automatic test_load_priority();
        // period is 63 from the previous test; rst below must clear it.
        load = 1'b1; out_ready = 1'b1; seed_in = 6'b000111;
        step();
        load = 1'b0;
        checks++;
        if (rand_out !== 6'b000111) begin
            errors++;
            $display("FAIL load_priority: rand=%b want 000111", rand_out);
        end
        step();
        checks++;
        if (rand_out !== 6'b000011) begin
            errors++;
            $display("FAIL load_advance: rand=%b want 000011", rand_out);
        end
        rst = 1'b1; load = 1'b1; seed_in = 6'b110000;
        step();
        rst = 1'b0; load = 1'b0; out_ready = 1'b0;
        checks++;
        if (rand_out !== 6'b000001 || period !== 6'd0 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL rst_midseq: rand=%b period=%0d valid=%b, want 000001 0 1",
                     rand_out, period, out_valid);
        end
    endtask

    task automatic test_hold();
        int bad = 0;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step();
            if (rand_out !== 6'b000001) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL hold: %0d cycles changed, want 0 (rand=%b)", bad, rand_out);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checks++;
        if (rand_out !== 6'b100000) begin
            errors++;
            $display("FAIL hold_release: rand=%b want 100000", rand_out);
        end
        step();
        checks++;
        if (rand_out !== 6'b100000) begin
            errors++;
            $display("FAIL hold_after: rand=%b want 100000", rand_out);
        end
    endtask

    task automatic test_lockup();
        int bad = 0;
        load = 1'b1; seed_in = 6'b000000;
        step();
        load = 1'b0; out_ready = 1'b1;
        checks++;
        if (lockup !== 1'b1 || out_valid !== 1'b0 || rand_out !== 6'b000000) begin
            errors++;
            $display("FAIL lock_enter: lock=%b valid=%b rand=%b, want 1 0 000000",
                     lockup, out_valid, rand_out);
        end
        for (int i = 0; i < 20; i++) begin
            step();
            if (lockup !== 1'b1 || out_valid !== 1'b0 || rand_out !== 6'b000000) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL lock_stable: %0d bad cycles, want 0", bad);
        end
        load = 1'b1; seed_in = 6'b101010;
        step();
        load = 1'b0; out_ready = 1'b0;
        checks++;
        if (lockup !== 1'b0 || out_valid !== 1'b1 || rand_out !== 6'b101010) begin
            errors++;
            $display("FAIL lock_exit: lock=%b valid=%b rand=%b, want 0 1 101010",
                     lockup, out_valid, rand_out);
        end
        // 101010: bit0^bit1 = 1 -> 110101
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checks++;
        if (rand_out !== 6'b110101) begin
            errors++;
            $display("FAIL lock_exit_adv: rand=%b want 110101", rand_out);
        end
    endtask

    task automatic test_locked_reset();
        load = 1'b1; seed_in = 6'b000000;
        step();
        load = 1'b0;
        rst = 1'b1; load = 1'b1; seed_in = 6'b000000;
        step();
        rst = 1'b0; load = 1'b0;
        checks++;
        if (lockup !== 1'b0 || out_valid !== 1'b1 || rand_out !== 6'b000001) begin
            errors++;
            $display("FAIL locked_rst: lock=%b valid=%b rand=%b, want 0 1 000001",
                     lockup, out_valid, rand_out);
        end
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; seed_in = '0; out_ready = 1'b0;
        test_reset();
        test_sequence();
        test_period();
        test_load_priority();
        test_hold();
        test_lockup();
        test_locked_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
